// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one spi_master among N emesh requesters
module spi_master_arbiter #(
    parameter int N = 4,
    parameter int AW = 32,
    parameter int PW = 104,
    parameter int TW = 16,
    parameter logic [TW-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            hw_en,
    input  logic [N-1:0]    access_in,
    input  logic [N*PW-1:0] packet_in,
    output logic [N-1:0]    wait_out,
    output logic [N-1:0]    access_out,
    output logic [PW-1:0]   packet_out,
    input  logic            wait_in,
    output logic            m_access_out,
    output logic [PW-1:0]   m_packet_out,
    input  logic            m_wait_in,
    input  logic            m_access_in,
    input  logic [PW-1:0]   m_packet_in,
    output logic            m_wait_out,
    output logic            busy,
    output logic            timeout_err,
    output logic            stray_err
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] TLAST = TIMEOUT - TW'(1);

    if (AW > PW) begin : g_aw_chk
        $error("AW exceeds PW");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;

    logic [IW-1:0] rr, rr_nx, win, owner;
    logic [IW:0]   sum, w1;
    logic          found, grant, tmo;
    logic [PW-1:0] req_pkt [N];
    logic [PW-1:0] pkt, resp;
    logic [TW-1:0] cnt;

    genvar i;
    for (i = 0; i < N; i++) begin : g_pkt
        assign req_pkt[i] = packet_in[i*PW +: PW];
    end

    always_comb begin
        found = 1'b0;
        win = rr;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr} + (IW+1)'(k);
            sum = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
            if (!found && access_in[sum[IW-1:0]]) begin
                found = 1'b1;
                win = sum[IW-1:0];
            end
        end
    end

    assign grant = (state == IDLE) && hw_en && found;
    assign w1 = {1'b0, win} + (IW+1)'(1);
    assign rr_nx = (w1 == (IW+1)'(N)) ? '0 : w1[IW-1:0];

    always_comb begin
        state_nx = state;
        tmo = 1'b0;
        case (state)
            IDLE:  state_nx = grant ? ISSUE : IDLE;
            ISSUE: state_nx = m_wait_in ? ISSUE : (pkt[0] ? IDLE : WAIT);
            WAIT: begin
                tmo = !m_access_in && (TIMEOUT != '0) && (cnt == TLAST);
                state_nx = m_access_in ? RESP : (tmo ? IDLE : WAIT);
            end
            RESP:    state_nx = wait_in ? RESP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            rr          <= '0;
            owner       <= '0;
            pkt         <= '0;
            resp        <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            stray_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            timeout_err <= tmo;
            stray_err   <= m_access_in && (state != WAIT);
            cnt         <= (state == ISSUE) ? '0 : ((state == WAIT) && !(&cnt)) ? cnt + TW'(1) : cnt;
            if (grant) begin
                pkt   <= req_pkt[win];
                owner <= win;
                rr    <= rr_nx;
            end
            if ((state == WAIT) && m_access_in)
                resp <= m_packet_in;
        end
    end

    assign busy         = state != IDLE;
    assign wait_out     = grant ? ~(N'(1) << win) : '1;
    assign m_access_out = state == ISSUE;
    assign m_packet_out = (state == ISSUE) ? pkt : '0;
    assign access_out   = (state == RESP) ? (N'(1) << owner) : '0;
    assign packet_out   = (state == RESP) ? resp : '0;
    assign m_wait_out   = state == RESP;
endmodule
